// File: rtl/io_bank_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : io_bank_cfg_ctrl
// Description : Configurable IO bank of NUM_IO cells at a fabric edge. Each
//               cell has a 2-bit mode (00 disabled, 01 input, 10 output,
//               11 bidirectional).
//
//               Configuration data is shifted in on the ccff chain into a
//               staging register. The staging register is copied into the
//               active configuration in a single step, and only if the
//               session shifted exactly 2*NUM_IO bits. During a session the
//               pads keep their previous behaviour.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   prog_clk          in   configuration clock (only clock)
//   pReset            in   synchronous active-high reset
//   config_enable     in   chain shift enable / session window
//   IO_ISOL_N         in   active-low global pad isolation
//   ccff_head         in   chain serial in
//   ccff_tail         out  chain serial out (registered)
//   gfpga_pad_sofa_plus_io_SOC_IN   in   pad -> core data
//   gfpga_pad_sofa_plus_io_SOC_OUT  out  core -> pad data
//   gfpga_pad_sofa_plus_io_SOC_DIR  out  1 = pad is input, 0 = pad drives
//   fabric_outpad     in   fabric data toward the pad
//   fabric_oe         in   fabric output enable (bidir mode only)
//   fabric_inpad      out  pad data toward the fabric
//   cfg_done          out  active configuration valid, no session running
//   cfg_error         out  last session had the wrong bit count
// ============================================================================
module io_bank_cfg_ctrl #(
    parameter int NUM_IO = 9,
    parameter int CNT_W  = $clog2(2*NUM_IO+2)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              config_enable,
    input  logic              IO_ISOL_N,
    input  logic              ccff_head,
    output logic              ccff_tail,
    input  logic [NUM_IO-1:0] gfpga_pad_sofa_plus_io_SOC_IN,
    output logic [NUM_IO-1:0] gfpga_pad_sofa_plus_io_SOC_OUT,
    output logic [NUM_IO-1:0] gfpga_pad_sofa_plus_io_SOC_DIR,
    input  logic [NUM_IO-1:0] fabric_outpad,
    input  logic [NUM_IO-1:0] fabric_oe,
    output logic [NUM_IO-1:0] fabric_inpad,
    output logic              cfg_done,
    output logic              cfg_error
);

    localparam int               c_SR_W      = 2*NUM_IO;
    localparam logic [CNT_W-1:0] c_BITS_FULL = CNT_W'(2*NUM_IO);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

    logic [c_SR_W-1:0] sr_q,      sr_d;
    logic [c_SR_W-1:0] active_q,  active_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              tail_q,    tail_d;
    logic              done_q,    done_d;
    logic              error_q,   error_d;
    logic              en_dly_q;

    // ------------------------------------------------------------------
    // Next-state logic for the chain, the session counter and the commit
    // ------------------------------------------------------------------
    always_comb begin
        sr_d      = sr_q;
        tail_d    = tail_q;
        active_d  = active_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = done_q;
        error_d   = error_q;

        if (config_enable) begin
            sr_d   = {sr_q[c_SR_W-2:0], ccff_head};
            tail_d = sr_q[c_SR_W-1];
        end

        if (config_enable && !en_dly_q) begin
            // First cycle of a session already shifts one bit.
            bit_cnt_d = c_CNT_ONE;
            done_d    = 1'b0;
        end else if (config_enable) begin
            // Saturate so an over-long session can never wrap back onto
            // the legal length and commit garbage.
            if (bit_cnt_q != {CNT_W{1'b1}}) begin
                bit_cnt_d = bit_cnt_q + c_CNT_ONE;
            end
        end else if (en_dly_q) begin
            // Falling edge of config_enable: commit or flag an error.
            if (bit_cnt_q == c_BITS_FULL) begin
                active_d = sr_q;
                done_d   = 1'b1;
                error_d  = 1'b0;
            end else begin
                done_d   = 1'b0;
                error_d  = 1'b1;
            end
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            sr_q      <= '0;
            active_q  <= '0;
            bit_cnt_q <= '0;
            tail_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            en_dly_q  <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            active_q  <= active_d;
            bit_cnt_q <= bit_cnt_d;
            tail_q    <= tail_d;
            done_q    <= done_d;
            error_q   <= error_d;
            en_dly_q  <= config_enable;
        end
    end

    assign ccff_tail = tail_q;
    assign cfg_done  = done_q;
    assign cfg_error = error_q;

    // ------------------------------------------------------------------
    // Per-cell pad datapath, gated by global isolation
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_IO; k++) begin : g_cell
        logic [1:0] w_mode;
        logic       w_dir;
        logic       w_out;
        logic       w_inp;

        assign w_mode = active_q[2*k+1 -: 2];

        always_comb begin
            w_dir = 1'b1;
            w_out = 1'b0;
            w_inp = 1'b0;
            case (w_mode)
                2'b01: begin
                    w_inp = gfpga_pad_sofa_plus_io_SOC_IN[k];
                end
                2'b10: begin
                    w_dir = 1'b0;
                    w_out = fabric_outpad[k];
                end
                2'b11: begin
                    w_dir = ~fabric_oe[k];
                    w_out = fabric_outpad[k];
                    w_inp = gfpga_pad_sofa_plus_io_SOC_IN[k];
                end
                default: begin
                    w_dir = 1'b1;
                    w_out = 1'b0;
                    w_inp = 1'b0;
                end
            endcase
        end

        assign gfpga_pad_sofa_plus_io_SOC_DIR[k] = ~IO_ISOL_N | w_dir;
        assign gfpga_pad_sofa_plus_io_SOC_OUT[k] =  IO_ISOL_N & w_out;
        assign fabric_inpad[k]                   =  IO_ISOL_N & w_inp;
    end

endmodule
`default_nettype wire

// File: tb/tb_io_bank_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_bank_cfg_ctrl
// Description : Self-checking bench for io_bank_cfg_ctrl (NUM_IO = 9).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_bank_cfg_ctrl;

    localparam int NUM_IO = 9;

    logic              prog_clk = 1'b0;
    logic              pReset;
    logic              config_enable;
    logic              IO_ISOL_N;
    logic              ccff_head;
    logic              ccff_tail;
    logic [NUM_IO-1:0] soc_in;
    logic [NUM_IO-1:0] soc_out;
    logic [NUM_IO-1:0] soc_dir;
    logic [NUM_IO-1:0] fabric_outpad;
    logic [NUM_IO-1:0] fabric_oe;
    logic [NUM_IO-1:0] fabric_inpad;
    logic              cfg_done;
    logic              cfg_error;

    always #5 prog_clk = ~prog_clk;

    io_bank_cfg_ctrl #(.NUM_IO(NUM_IO)) dut (
        .prog_clk                       (prog_clk),
        .pReset                         (pReset),
        .config_enable                  (config_enable),
        .IO_ISOL_N                      (IO_ISOL_N),
        .ccff_head                      (ccff_head),
        .ccff_tail                      (ccff_tail),
        .gfpga_pad_sofa_plus_io_SOC_IN  (soc_in),
        .gfpga_pad_sofa_plus_io_SOC_OUT (soc_out),
        .gfpga_pad_sofa_plus_io_SOC_DIR (soc_dir),
        .fabric_outpad                  (fabric_outpad),
        .fabric_oe                      (fabric_oe),
        .fabric_inpad                   (fabric_inpad),
        .cfg_done                       (cfg_done),
        .cfg_error                      (cfg_error)
    );

    typedef struct packed {
        logic       isol_n;
        logic [8:0] soc_in;
        logic [8:0] outpad;
        logic [8:0] oe;
        logic [8:0] exp_dir;
        logic [8:0] exp_out;
        logic [8:0] exp_inpad;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t sb_q[$];
    logic exp_tail_q[$];
    logic bits [0:511];
    vec_t tbl [0:6];
    vec_t v_cfg;   // scenario-2 configuration, all inputs high, oe[2]=1
    vec_t v_off;   // every cell disabled, all inputs high

    // cell0=01, cell1=10, cell2=11, cells 3..8 = 00
    localparam logic [17:0] c_PAT = 18'h00039;

    function automatic vec_t mk(input logic i, input logic [8:0] si, input logic [8:0] op,
                                input logic [8:0] oe, input logic [8:0] d,
                                input logic [8:0] o, input logic [8:0] ip);
        vec_t v;
        v.isol_n = i;  v.soc_in = si; v.outpad = op; v.oe = oe;
        v.exp_dir = d; v.exp_out = o; v.exp_inpad = ip;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    // Drive pad-side inputs, queue the expected pad outputs, then compare.
    task automatic apply_vec(input vec_t v, input string tag);
        vec_t e;
        IO_ISOL_N     = v.isol_n;
        soc_in        = v.soc_in;
        fabric_outpad = v.outpad;
        fabric_oe     = v.oe;
        sb_q.push_back(v);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_dir"},   32'(soc_dir),      32'(e.exp_dir));
            chk({tag, "_out"},   32'(soc_out),      32'(e.exp_out));
            chk({tag, "_inpad"}, 32'(fabric_inpad), 32'(e.exp_inpad));
        end
    endtask

    task automatic set_pattern(input logic [17:0] p);
        for (int i = 0; i < 18; i++) bits[i] = p[17-i];
    endtask

    // Shift bits[0..n-1], bits[0] first. Leaves config_enable high.
    task automatic shift_bits(input int n, input bit chk_tail);
        logic e;
        exp_tail_q.delete();
        for (int i = 0; i < n; i++) begin
            config_enable = 1'b1;
            ccff_head     = bits[i];
            exp_tail_q.push_back(bits[i]);
            tick();
            if (i == 0) chk("done_low_in_session", 32'(cfg_done), 32'd0);
            if (chk_tail && exp_tail_q.size() > 18) begin
                e = exp_tail_q.pop_front();
                chk($sformatf("ccff_tail_shift%0d", i+1), 32'(ccff_tail), 32'(e));
            end
        end
    endtask

    // Drop config_enable; the following edge is the commit edge.
    task automatic end_session();
        config_enable = 1'b0;
        ccff_head     = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        v_cfg  = mk(1'b1, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1F9, 9'h006, 9'h005);
        v_off  = mk(1'b1, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 9'h000, 9'h000);
        tbl[0] = v_cfg;
        tbl[1] = mk(1'b1, 9'h1FF, 9'h1FF, 9'h000, 9'h1FD, 9'h006, 9'h005);
        tbl[2] = mk(1'b1, 9'h000, 9'h000, 9'h1FF, 9'h1F9, 9'h000, 9'h000);
        tbl[3] = mk(1'b1, 9'h1FA, 9'h005, 9'h004, 9'h1F9, 9'h004, 9'h000);
        tbl[4] = mk(1'b1, 9'h005, 9'h002, 9'h1FB, 9'h1FD, 9'h002, 9'h005);
        tbl[5] = mk(1'b0, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 9'h000, 9'h000);
        tbl[6] = v_cfg;

        pReset        = 1'b1;
        config_enable = 1'b0;
        ccff_head     = 1'b0;
        IO_ISOL_N     = 1'b1;
        soc_in        = 9'h1FF;
        fabric_outpad = 9'h1FF;
        fabric_oe     = 9'h1FF;

        // Reset state
        tick();
        tick();
        chk("rst_done",  32'(cfg_done),  32'd0);
        chk("rst_error", 32'(cfg_error), 32'd0);
        chk("rst_tail",  32'(ccff_tail), 32'd0);
        apply_vec(v_off, "rst_pads");
        pReset = 1'b0;
        tick();

        // Legal 18-bit session, then datapath table incl. isolation pulse
        set_pattern(c_PAT);
        shift_bits(18, 1'b0);
        end_session();
        chk("s2_done",  32'(cfg_done),  32'd1);
        chk("s2_error", 32'(cfg_error), 32'd0);
        for (int i = 0; i < 7; i++) apply_vec(tbl[i], $sformatf("tbl%0d", i));

        // Short session: error, pads unchanged; next legal session clears it
        shift_bits(17, 1'b0);
        end_session();
        chk("s3_error", 32'(cfg_error), 32'd1);
        chk("s3_done",  32'(cfg_done),  32'd0);
        apply_vec(v_cfg, "s3_hold");
        set_pattern(c_PAT);
        shift_bits(18, 1'b0);
        end_session();
        chk("s3_fix_error", 32'(cfg_error), 32'd0);
        chk("s3_fix_done",  32'(cfg_done),  32'd1);

        // Single-cycle session
        shift_bits(1, 1'b0);
        end_session();
        chk("pulse_error", 32'(cfg_error), 32'd1);
        chk("pulse_done",  32'(cfg_done),  32'd0);
        apply_vec(v_cfg, "pulse_hold");

        // 36-bit random session: chain pass-through and length error
        for (int i = 0; i < 36; i++) bits[i] = 1'($urandom_range(0, 1));
        shift_bits(36, 1'b1);
        end_session();
        chk("s5_error", 32'(cfg_error), 32'd1);
        apply_vec(v_cfg, "s5_hold");

        // 306 bits: a 5-bit counter that wrapped would read 18 here and
        // commit all-zero modes; saturation must prevent that.
        for (int i = 0; i < 306; i++) bits[i] = 1'b0;
        shift_bits(306, 1'b0);
        end_session();
        chk("long_error", 32'(cfg_error), 32'd1);
        chk("long_done",  32'(cfg_done),  32'd0);
        apply_vec(v_cfg, "long_hold");

        // Reset on bit 10 of a session
        set_pattern(c_PAT);
        shift_bits(9, 1'b0);
        pReset        = 1'b1;
        config_enable = 1'b1;
        ccff_head     = bits[9];
        tick();
        pReset        = 1'b0;
        config_enable = 1'b0;
        chk("midrst_done",  32'(cfg_done),  32'd0);
        chk("midrst_error", 32'(cfg_error), 32'd0);
        chk("midrst_tail",  32'(ccff_tail), 32'd0);
        apply_vec(v_off, "midrst_pads");
        tick();
        chk("midrst_nocommit_done",  32'(cfg_done),  32'd0);
        chk("midrst_nocommit_error", 32'(cfg_error), 32'd0);
        shift_bits(18, 1'b0);
        end_session();
        chk("midrst_next_done",  32'(cfg_done),  32'd1);
        chk("midrst_next_error", 32'(cfg_error), 32'd0);
        apply_vec(v_cfg, "midrst_next_pads");

        // Reset on the commit edge wins
        shift_bits(18, 1'b0);
        config_enable = 1'b0;
        pReset        = 1'b1;
        tick();
        pReset = 1'b0;
        chk("cmtrst_done",  32'(cfg_done),  32'd0);
        chk("cmtrst_error", 32'(cfg_error), 32'd0);
        apply_vec(v_off, "cmtrst_pads");
        tick();
        chk("cmtrst_after_done", 32'(cfg_done), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
